// File: rtl/aes_cipher_ctrl_if.sv
// Host/datapath handshake bundle for the AES-128 bit-serial cipher sequencer.
// master = host/datapath side, slave = the sequencing controller.
interface aes_cipher_ctrl_if;
   logic       start;
   logic       mode;
   logic       hold;
   logic       EN;
   logic       WR_EN_IN_REG;
   logic       WR_EN_STATE_REG;
   logic       WR_EN_OUT_REG;
   logic [2:0] Sel_State;
   logic [3:0] Sel_Key;
   logic       din_req;
   logic       dout_valid;
   logic       busy;
   logic       done;

   modport master (
      output start, mode, hold,
      input  EN, WR_EN_IN_REG, WR_EN_STATE_REG, WR_EN_OUT_REG,
      input  Sel_State, Sel_Key, din_req, dout_valid, busy, done
   );

   modport slave (
      input  start, mode, hold,
      output EN, WR_EN_IN_REG, WR_EN_STATE_REG, WR_EN_OUT_REG,
      output Sel_State, Sel_Key, din_req, dout_valid, busy, done
   );
endinterface

// File: rtl/aes_cipher_ctrl.sv
// Sequencing FSM for the AES-128 bit-serial cipher datapath: serial load, 41-cycle core,
// serial unload. Selects and write enables are registered from the next-state decode.
module aes_cipher_ctrl #(
   parameter int NR         = 10,
   parameter int BLOCK_BITS = 128
) (
   input logic               clk,
   input logic               reset_n,
   aes_cipher_ctrl_if.slave  bus
);
   localparam int              CW         = $clog2(BLOCK_BITS);
   localparam logic [CW-1:0]   LAST_BIT   = CW'(BLOCK_BITS - 1);
   localparam logic [3:0]      LAST_KEY   = 4'(NR);
   localparam logic [3:0]      LAST_ROUND = 4'(NR - 1);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_CAPTURE  = 3'd2,
      ST_ARK_INIT = 3'd3,
      ST_ROUND    = 3'd4,
      ST_FINAL    = 3'd5,
      ST_OUT_LOAD = 3'd6,
      ST_SHIFT    = 3'd7
   } state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] bit_r, bit_s;
   logic [1:0]    step_r, step_s;
   logic [3:0]    round_r, round_s;
   logic          mode_r, mode_s;
   logic          busy_r, busy_s;
   logic          done_r, done_s;
   logic          wr_in_r, wr_in_s;
   logic          wr_state_r, wr_state_s;
   logic          wr_out_r, wr_out_s;
   logic          dout_r, dout_s;
   logic [2:0]    sel_state_r, sel_state_s;
   logic [3:0]    sel_key_r, sel_key_s;

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         bit_r       <= '0;
         step_r      <= 2'd0;
         round_r     <= 4'd0;
         mode_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         wr_in_r     <= 1'b0;
         wr_state_r  <= 1'b0;
         wr_out_r    <= 1'b0;
         dout_r      <= 1'b0;
         sel_state_r <= 3'd0;
         sel_key_r   <= 4'd0;
      end else begin
         state_r     <= state_s;
         bit_r       <= bit_s;
         step_r      <= step_s;
         round_r     <= round_s;
         mode_r      <= mode_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         wr_in_r     <= wr_in_s;
         wr_state_r  <= wr_state_s;
         wr_out_r    <= wr_out_s;
         dout_r      <= dout_s;
         sel_state_r <= sel_state_s;
         sel_key_r   <= sel_key_s;
      end
   end

   // Next-state sequencing, then output decode of the state being entered.
   always_comb begin
      state_s = state_r;
      bit_s   = bit_r;
      step_s  = step_r;
      round_s = round_r;
      mode_s  = mode_r;
      busy_s  = busy_r;
      done_s  = 1'b0;

      if (bus.hold) begin
         state_s = state_r;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  state_s = ST_LOAD;
                  mode_s  = bus.mode;
                  bit_s   = '0;
                  busy_s  = 1'b1;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (bit_r == LAST_BIT) begin
                  state_s = ST_CAPTURE;
                  bit_s   = '0;
               end else begin
                  bit_s = bit_r + 1'b1;
               end
            end
            ST_CAPTURE:  state_s = ST_ARK_INIT;
            ST_ARK_INIT: begin
               state_s = ST_ROUND;
               step_s  = 2'd0;
               round_s = mode_r ? LAST_ROUND : 4'd1;
            end
            ST_ROUND: begin
               // A round index outside 1..NR-1 can only come from an upset; bail out.
               if ((round_r < 4'd1) || (round_r > LAST_ROUND)) begin
                  state_s = ST_IDLE;
                  busy_s  = 1'b0;
               end else if (step_r == 2'd3) begin
                  step_s = 2'd0;
                  if (mode_r ? (round_r == 4'd1) : (round_r == LAST_ROUND)) begin
                     state_s = ST_FINAL;
                  end else begin
                     round_s = mode_r ? (round_r - 4'd1) : (round_r + 4'd1);
                  end
               end else begin
                  step_s = step_r + 2'd1;
               end
            end
            ST_FINAL: begin
               if (step_r == 2'd0) begin
                  step_s = 2'd1;
               end else begin
                  state_s = ST_OUT_LOAD;
                  step_s  = 2'd0;
               end
            end
            ST_OUT_LOAD: begin
               state_s = ST_SHIFT;
               bit_s   = '0;
            end
            ST_SHIFT: begin
               if (bit_r == LAST_BIT) begin
                  state_s = ST_IDLE;
                  bit_s   = '0;
                  busy_s  = 1'b0;
                  done_s  = 1'b1;
               end else begin
                  bit_s = bit_r + 1'b1;
               end
            end
            default: begin
               state_s = ST_IDLE;
               busy_s  = 1'b0;
            end
         endcase
      end

      wr_in_s     = (state_s == ST_LOAD);
      wr_out_s    = (state_s == ST_OUT_LOAD);
      dout_s      = (state_s == ST_SHIFT);
      wr_state_s  = (state_s == ST_CAPTURE) || (state_s == ST_ARK_INIT) ||
                    (state_s == ST_ROUND)   || (state_s == ST_FINAL);
      sel_state_s = sel_state_r;
      sel_key_s   = sel_key_r;

      case (state_s)
         ST_CAPTURE:  sel_state_s = 3'd0;
         ST_ARK_INIT: begin
            sel_state_s = 3'd4;
            sel_key_s   = mode_s ? LAST_KEY : 4'd0;
         end
         ST_ROUND: begin
            case (step_s)
               2'd0: sel_state_s = mode_s ? 3'd6 : 3'd1;
               2'd1: sel_state_s = mode_s ? 3'd5 : 3'd2;
               2'd2: begin
                  if (mode_s) begin
                     sel_state_s = 3'd4;
                     sel_key_s   = round_s;
                  end else begin
                     sel_state_s = 3'd3;
                  end
               end
               2'd3: begin
                  if (mode_s) begin
                     sel_state_s = 3'd7;
                  end else begin
                     sel_state_s = 3'd4;
                     sel_key_s   = round_s;
                  end
               end
               default: sel_state_s = sel_state_r;
            endcase
         end
         ST_FINAL: begin
            if (step_s == 2'd0) begin
               sel_state_s = mode_s ? 3'd6 : 3'd1;
            end else begin
               sel_state_s = mode_s ? 3'd5 : 3'd2;
            end
         end
         // The final AddRoundKey feeds the output register directly.
         ST_OUT_LOAD: sel_key_s = mode_s ? 4'd0 : LAST_KEY;
         default: begin
            sel_state_s = sel_state_r;
            sel_key_s   = sel_key_r;
         end
      endcase
   end

   assign bus.EN              = busy_r & ~bus.hold;
   assign bus.WR_EN_IN_REG    = wr_in_r & ~bus.hold;
   assign bus.WR_EN_STATE_REG = wr_state_r & ~bus.hold;
   assign bus.WR_EN_OUT_REG   = wr_out_r & ~bus.hold;
   assign bus.din_req         = wr_in_r & ~bus.hold;
   assign bus.dout_valid      = dout_r & ~bus.hold;
   assign bus.Sel_State       = sel_state_r;
   assign bus.Sel_Key         = sel_key_r;
   assign bus.busy            = busy_r;
   assign bus.done            = done_r;
endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// Self-checking bench for aes_cipher_ctrl: per-cycle output trace compared against a
// step list built from the operation's round structure, with directed and random hold/start.
module tb_aes_cipher_ctrl;
   typedef struct packed {
      logic [7:0] fl;   // EN, wr_in, wr_state, wr_out, din_req, dout_valid, busy, done
      logic [2:0] sel;
      logic [3:0] key;
   } rec_t;

   localparam logic [7:0] F_LOAD  = 8'b1100_1010;
   localparam logic [7:0] F_STATE = 8'b1010_0010;
   localparam logic [7:0] F_OUTL  = 8'b1001_0010;
   localparam logic [7:0] F_SHIFT = 8'b1000_0110;
   localparam logic [7:0] F_DONE  = 8'b0000_0001;

   logic       clk;
   logic       reset_n;
   int         total;
   int         bad;
   int         cur_k;
   logic [2:0] m_sel;
   logic [3:0] m_key;
   rec_t       q[$];
   int         hold_plan[0:296];

   aes_cipher_ctrl_if bus ();

   aes_cipher_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] obs();
      return {bus.EN, bus.WR_EN_IN_REG, bus.WR_EN_STATE_REG, bus.WR_EN_OUT_REG,
              bus.din_req, bus.dout_valid, bus.busy, bus.done, bus.Sel_State, bus.Sel_Key};
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, cur_k, o, e);
      end
   endtask

   // sel/key of -1 means the select keeps its previous value.
   task automatic push(input logic [7:0] fl, input int sel, input int key);
      if (sel >= 0) m_sel = 3'(sel);
      if (key >= 0) m_key = 4'(key);
      q.push_back({fl, m_sel, m_key});
   endtask

   task automatic build(input bit dec);
      int r;
      q.delete();
      for (int i = 0; i < 128; i++) push(F_LOAD, -1, -1);
      push(F_STATE, 0, -1);
      push(F_STATE, 4, dec ? 10 : 0);
      for (int i = 0; i < 9; i++) begin
         r = dec ? (9 - i) : (1 + i);
         if (dec) begin
            push(F_STATE, 6, -1); push(F_STATE, 5, -1);
            push(F_STATE, 4, r);  push(F_STATE, 7, -1);
         end else begin
            push(F_STATE, 1, -1); push(F_STATE, 2, -1);
            push(F_STATE, 3, -1); push(F_STATE, 4, r);
         end
      end
      if (dec) begin
         push(F_STATE, 6, -1); push(F_STATE, 5, -1);
      end else begin
         push(F_STATE, 1, -1); push(F_STATE, 2, -1);
      end
      push(F_OUTL, -1, dec ? 0 : 10);
      for (int i = 0; i < 128; i++) push(F_SHIFT, -1, -1);
   endtask

   task automatic run_op(input bit dec, input bit noise, input int abort_k);
      rec_t done_rec;
      int   held;
      int   cyc;
      int   k;
      bit   fin;
      @(negedge clk);
      bus.hold  = 1'b0;
      bus.start = 1'b1;
      bus.mode  = dec;
      cur_k     = -1;
      #1 check("idle", 32'(obs()), {17'd0, 8'h00, m_sel, m_key});
      build(dec);
      done_rec = {F_DONE, m_sel, m_key};
      held = 0; cyc = 0; k = 0; fin = 1'b0;
      while (!fin && cyc < 1000) begin
         @(negedge clk);
         cyc++;
         cur_k = k;
         if (q.size() == 0) begin
            bus.start = 1'b0;
            bus.hold  = 1'b0;
            #1;
            check("done", 32'(obs()), 32'(done_rec));
            check("latency", cyc - 1, 297 + held);
            fin = 1'b1;
         end else if (k == abort_k) begin
            bus.start = 1'b0;
            bus.hold  = 1'b0;
            reset_n   = 1'b0;
            #1;
            check("abort", 32'(obs()), 32'd0);
            m_sel = 3'd0;
            m_key = 4'd0;
            repeat (2) begin
               @(negedge clk);
               #1 check("abort_quiet", 32'(obs()), 32'd0);
            end
            reset_n = 1'b1;
            fin     = 1'b1;
         end else begin
            if (hold_plan[k] > 0) begin
               bus.hold = 1'b1;
               hold_plan[k]--;
               held++;
            end else if (noise && ($urandom_range(0, 15) == 0)) begin
               bus.hold = 1'b1;
               held++;
            end else begin
               bus.hold = 1'b0;
            end
            if (noise) begin
               bus.start = 1'($urandom_range(0, 1));
               bus.mode  = 1'($urandom_range(0, 1));
            end else begin
               bus.start = 1'b0;
            end
            #1;
            if (bus.hold) begin
               check("held", 32'(obs()), {17'd0, q[0].fl & 8'h02, q[0].sel, q[0].key});
            end else begin
               check("step", 32'(obs()), 32'(q[0]));
               void'(q.pop_front());
               k++;
            end
         end
      end
      if (!fin) begin
         check("timeout", 32'(fin), 32'd1);
      end else if (abort_k < 0) begin
         @(negedge clk);
         bus.start = 1'b0;
         #1 check("done_pulse", 32'(obs()), {17'd0, 8'h00, m_sel, m_key});
      end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      cur_k     = -1;
      m_sel     = 3'd0;
      m_key     = 4'd0;
      reset_n   = 1'b0;
      bus.start = 1'b0;
      bus.mode  = 1'b0;
      bus.hold  = 1'b0;
      for (int i = 0; i < 297; i++) hold_plan[i] = 0;
      repeat (3) @(negedge clk);
      #1 check("reset", 32'(obs()), 32'd0);
      reset_n = 1'b1;

      // Encrypt, then decrypt, no hold.
      run_op(1'b0, 1'b0, -1);
      run_op(1'b1, 1'b0, -1);

      // Directed holds: LOAD bit 64, round 5 MC, SHIFT bit 127.
      hold_plan[64]  = 5;
      hold_plan[148] = 3;
      hold_plan[296] = 2;
      run_op(1'b0, 1'b0, -1);

      // start together with hold in IDLE is not accepted.
      @(negedge clk);
      bus.start = 1'b1;
      bus.hold  = 1'b1;
      #1 check("idle_hold", 32'(obs()), {17'd0, 8'h00, m_sel, m_key});
      @(negedge clk);
      bus.start = 1'b0;
      bus.hold  = 1'b0;
      #1 check("not_accepted", 32'(obs()), {17'd0, 8'h00, m_sel, m_key});

      // Reset during SHIFT bit 40, then a fresh encrypt.
      run_op(1'b0, 1'b0, 209);
      run_op(1'b0, 1'b0, -1);

      // Random hold plus start/mode noise while busy.
      run_op(1'b0, 1'b1, -1);
      for (int i = 0; i < 4; i++) run_op(1'($urandom_range(0, 1)), 1'b1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
